sprite_scheduler: RTL
=====================

Name: sprite_scheduler

Overview:
- Shares one synchronous image SRAM between NUM_SPRITES fixed-size rectangular sprite windows on the VGA raster.
- Each pixel: selects the highest-priority enabled sprite covering (vga_x, vga_y), issues its SRAM address, and returns a pipeline-aligned color/color_on pair to the pixel mux.
- Sprite positions and enables are written at any time through a config port. They take effect only at frame_start, so frames never tear.

Parameters:
- NUM_SPRITES, 4, sprite slots; slot 0 has the highest priority.
- WIDTH, 64, sprite width in pixels (all slots).
- HEIGHT, 32, sprite height in lines (all slots).
- ADDR_WIDTH, 13, SRAM address width; must satisfy 2^ADDR_WIDTH >= NUM_SPRITES*WIDTH*HEIGHT.
- DATA_WIDTH, 12, RGB444 pixel width.
- TKEY, 12'hF0F, transparent color key (used only with SPRITE_TRANSPARENCY_EN).

Ports:
- clk  in  1  pixel clock; also clocks the SRAM.
- rst_n  in  1  asynchronous, active-low reset.
- vga_x  in  10  current pixel column.
- vga_y  in  9  current pixel line.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- cfg_we  in  1  config write strobe; always accepted.
- cfg_sel  in  $clog2(NUM_SPRITES)  target slot.
- cfg_en  in  1  slot enable value.
- cfg_x  in  10  slot top-left X.
- cfg_y  in  9  slot top-left Y.
- ram_addr  out  ADDR_WIDTH  SRAM read address.
- ram_data  in  DATA_WIDTH  SRAM read data, valid one clock after ram_addr.
- color_on  out  1  a sprite covers this pixel.
- color  out  DATA_WIDTH  pixel color; 0 when color_on=0.
- hit_id  out  $clog2(NUM_SPRITES)  winning slot index; 0 when no hit.

Behaviour:
- Reset (async, rst_n=0): pending and active registers cleared (all slots disabled, x=0, y=0); ram_addr=0; stage-1 hit=0; color_on=0; hit_id=0; color=0. Reset mid-frame takes effect immediately.
- Config write: on cfg_we, pending[cfg_sel] <= {cfg_en, cfg_x, cfg_y}. Back-to-back writes to the same slot: last one wins.
- Config apply: on frame_start, active <= pending for all slots. If cfg_we and frame_start occur in the same cycle, active takes the pre-write pending value; the new write becomes visible at the next frame_start.
- Hit test per slot i (combinational): active_en[i] && vga_x >= x_i && vga_x < x_i+WIDTH && vga_y >= y_i && vga_y < y_i+HEIGHT.
  - Sums computed at 11/10 bits, so windows past 1023/511 never wrap to 0; off-screen parts simply never match.
- Priority: lowest index among hitting slots wins. Overlapping slots never blend.
- Address: i*WIDTH*HEIGHT + (vga_y-y_i)*WIDTH + (vga_x-x_i), truncated to ADDR_WIDTH.
- Pipeline, input sampled at edge E0:
  - E0: ram_addr, hit1 and id1 registered. With no hit, ram_addr holds its previous value.
  - E1: SRAM registers data; color_on <= hit1; hit_id <= id1.
  - color = color_on ? ram_data : 0 (combinational).
  - Total latency 2 clocks from vga_x/vga_y to color/color_on; throughput one pixel per clock, no stalls.
- Everything is free-running and has no handshake beyond cfg_we.

Optional Feature:
- SPRITE_TRANSPARENCY_EN defined: at the output stage, if color_on_int && ram_data==TKEY, then color_on=0, color=0, hit_id=0. No fall-through to lower-priority slots.
- Undefined: TKEY is ignored and the pixel is shown as-is.

Decomposition:
- Package sprite_pkg holds:
  - RGB444 pixel typedef.
  - Slot-config struct typedef {en, x[9:0], y[8:0]}.
  - Constants SCREEN_W=640, SCREEN_H=480.
  - Function slot_base(i, w, h) returning i*w*h.
- One sub-module, sprite_hit, is instantiated per slot. It takes the slot config and vga_x/vga_y and produces the hit flag and local offset (vga_y-y)*WIDTH+(vga_x-x). The top level does the priority encoding, pipeline and config registers.

Test Plan:
- Reset, no config, raster sweep -> color_on=0, hit_id=0 and color=0 on every pixel.
- Write slot 1 en=1 x=100 y=50, pulse frame_start, drive (100,50) -> ram_addr=2048 one clock later; color_on=1, hit_id=1, color=ram_data two clocks after input.
- Drive (163,81) -> address 2048+31*64+63=4095. Drive (164,81) -> color_on=0.
- Slots 0 and 2 both enabled at x=200 y=100, drive (210,105) -> hit_id=0, ram_addr=5*64+10=330.
- cfg_we in the same cycle as frame_start (slot 3 en=1 x=0 y=0) -> no hit at (0,0) this frame. After the next frame_start, (0,0) gives ram_addr=6144 and hit_id=3.
- Slot 0 at x=1000 y=500, drive (1015,505) -> hit, addr=5*64+15=335; (0,0) -> no hit (no wrap).
- With SPRITE_TRANSPARENCY_EN, ram_data=12'hF0F -> color_on=0, color=0. Without the macro, the same stimulus gives color_on=1, color=12'hF0F.
- Assert rst_n low mid-line while color_on=1 -> color_on falls to 0 without waiting for a clock edge, and active config is cleared.

Source files
------------

// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pkg
// Purpose  : Shared types and helpers for the sprite scheduler.
//            - rgb444_t    : 12-bit RGB444 pixel
//            - slot_cfg_t  : per-slot configuration {en, x[9:0], y[8:0]}
//            - SCREEN_W/H  : visible raster size
//            - slot_base() : first SRAM word of a slot (i*w*h)
// Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    typedef logic [11:0] rgb444_t;

    typedef struct packed {
        logic       en;
        logic [9:0] x;
        logic [8:0] y;
    } slot_cfg_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    function automatic int slot_base(input int i, input int w, input int h);
        return i * w * h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_hit.sv
`default_nettype none
// ============================================================================
// Module   : sprite_hit
// Purpose  : Window hit test for one sprite slot plus the pixel offset
//            inside that slot's image, (y-y0)*WIDTH + (x-x0).
// Ports    : i_cfg     slot configuration (enable, top-left corner)
//            i_vga_x   current pixel column
//            i_vga_y   current pixel line
//            o_hit     slot enabled and pixel inside its window
//            o_offset  word offset inside the slot image (valid on o_hit)
// Revision : 1.0 - initial release
// ============================================================================
module sprite_hit
    import sprite_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 32,
    parameter int OFF_W  = 13
) (
    input  slot_cfg_t        i_cfg,
    input  logic [9:0]       i_vga_x,
    input  logic [8:0]       i_vga_y,
    output logic             o_hit,
    output logic [OFF_W-1:0] o_offset
);

    // Window ends carry one extra bit so a slot parked near 1023/511
    // never wraps around and matches pixels at the left/top edge.
    logic [10:0] w_x_end;
    logic [9:0]  w_y_end;
    logic [9:0]  w_dx;
    logic [8:0]  w_dy;

    assign w_x_end = {1'b0, i_cfg.x} + 11'(WIDTH);
    assign w_y_end = {1'b0, i_cfg.y} + 10'(HEIGHT);

    assign o_hit = i_cfg.en
                && (i_vga_x >= i_cfg.x) && ({1'b0, i_vga_x} < w_x_end)
                && (i_vga_y >= i_cfg.y) && ({1'b0, i_vga_y} < w_y_end);

    assign w_dx = i_vga_x - i_cfg.x;
    assign w_dy = i_vga_y - i_cfg.y;

    assign o_offset = OFF_W'(w_dy) * OFF_W'(WIDTH) + OFF_W'(w_dx);

endmodule
`default_nettype wire

// File: rtl/sprite_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sprite_scheduler
// Purpose  : Shares one synchronous image SRAM between NUM_SPRITES fixed-size
//            sprite windows. Per pixel it picks the lowest-index enabled slot
//            covering (vga_x, vga_y), issues its SRAM address and returns a
//            color/color_on pair two clocks after the coordinates.
//            Slot config is double-buffered: writes land in a pending copy
//            that is copied to the active copy on frame_start.
// Ports    : clk, rst_n            pixel clock, async active-low reset
//            vga_x, vga_y          raster position
//            frame_start           start of vertical blank (config apply)
//            cfg_we/sel/en/x/y     slot config write
//            ram_addr, ram_data    SRAM read port (data one clock later)
//            color_on, color       pixel output (color=0 when color_on=0)
//            hit_id                winning slot (0 when no hit)
// Options  : SPRITE_TRANSPARENCY_EN - pixels equal to TKEY are suppressed
//            (color_on=0, color=0, hit_id=0); no fall-through to lower
//            priority slots.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_scheduler
    import sprite_pkg::*;
#(
    parameter int                    NUM_SPRITES = 4,
    parameter int                    WIDTH       = 64,
    parameter int                    HEIGHT      = 32,
    parameter int                    ADDR_WIDTH  = 13,
    parameter int                    DATA_WIDTH  = 12,
    parameter logic [DATA_WIDTH-1:0] TKEY        = 12'hF0F
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [9:0]                     vga_x,
    input  logic [8:0]                     vga_y,
    input  logic                           frame_start,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_SPRITES)-1:0] cfg_sel,
    input  logic                           cfg_en,
    input  logic [9:0]                     cfg_x,
    input  logic [8:0]                     cfg_y,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    input  logic [DATA_WIDTH-1:0]          ram_data,
    output logic                           color_on,
    output logic [DATA_WIDTH-1:0]          color,
    output logic [$clog2(NUM_SPRITES)-1:0] hit_id
);

    localparam int c_SEL_W = $clog2(NUM_SPRITES);

`ifdef SPRITE_TRANSPARENCY_EN
    localparam logic c_TRANSP_EN = 1'b1;
`else
    localparam logic c_TRANSP_EN = 1'b0;
`endif

    slot_cfg_t pending_q [NUM_SPRITES];
    slot_cfg_t pending_d [NUM_SPRITES];
    slot_cfg_t active_q  [NUM_SPRITES];
    slot_cfg_t active_d  [NUM_SPRITES];

    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  hit1_q, hit1_d;
    logic [c_SEL_W-1:0]    id1_q, id1_d;
    logic                  color_on_q, color_on_d;
    logic [c_SEL_W-1:0]    hit_id_q, hit_id_d;

    logic [NUM_SPRITES-1:0] w_hit;
    logic [ADDR_WIDTH-1:0]  w_offset [NUM_SPRITES];
    logic                   w_any;
    logic [c_SEL_W-1:0]     w_id;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic                   w_key;

    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
            sprite_hit #(
                .WIDTH  (WIDTH),
                .HEIGHT (HEIGHT),
                .OFF_W  (ADDR_WIDTH)
            ) u_hit (
                .i_cfg    (active_q[gi]),
                .i_vga_x  (vga_x),
                .i_vga_y  (vga_y),
                .o_hit    (w_hit[gi]),
                .o_offset (w_offset[gi])
            );
        end
    endgenerate

    // Walk from the lowest priority upward so the last assignment made is
    // the lowest-index hitting slot.
    always_comb begin
        w_any  = 1'b0;
        w_id   = '0;
        w_addr = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any  = 1'b1;
                w_id   = c_SEL_W'(i);
                w_addr = ADDR_WIDTH'(slot_base(i, WIDTH, HEIGHT)) + w_offset[i];
            end
        end
    end

    // frame_start copies the pending values as they were before any write
    // in the same cycle, so a coincident write waits for the next frame.
    always_comb begin
        pending_d = pending_q;
        active_d  = active_q;
        if (frame_start) begin
            active_d = pending_q;
        end
        if (cfg_we) begin
            pending_d[cfg_sel] = '{en: cfg_en, x: cfg_x, y: cfg_y};
        end
    end

    always_comb begin
        ram_addr_d = w_any ? w_addr : ram_addr_q;
        hit1_d     = w_any;
        id1_d      = w_id;
        color_on_d = hit1_q;
        hit_id_d   = id1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                pending_q[i] <= '0;
                active_q[i]  <= '0;
            end
            ram_addr_q <= '0;
            hit1_q     <= 1'b0;
            id1_q      <= '0;
            color_on_q <= 1'b0;
            hit_id_q   <= '0;
        end else begin
            pending_q  <= pending_d;
            active_q   <= active_d;
            ram_addr_q <= ram_addr_d;
            hit1_q     <= hit1_d;
            id1_q      <= id1_d;
            color_on_q <= color_on_d;
            hit_id_q   <= hit_id_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign w_key    = c_TRANSP_EN && (ram_data == TKEY);
    assign color_on = color_on_q && !w_key;
    assign color    = color_on ? ram_data : '0;
    assign hit_id   = color_on ? hit_id_q : '0;

endmodule
`default_nettype wire
